// File: rtl/chess_clock_timer.sv
// Two-player chess clock: per-player whole-second countdown with pause, turn switch
// and timeout. Every output is a register or is decoded from registers only.
module chess_clock_timer #(
  parameter int CLK_HZ        = 50000000,
  parameter int START_SECONDS = 180
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       move_done,
  input  logic       pause,
  output logic [7:0] time_white,
  output logic [7:0] time_black,
  output logic [7:0] display_value,
  output logic       active_black,
  output logic       running,
  output logic       timeout
);

  localparam int              PW         = $clog2(CLK_HZ);
  localparam logic [PW-1:0]   PRESC_MAX  = PW'(CLK_HZ - 1);
  localparam logic [7:0]      START_TIME = 8'(START_SECONDS);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    RUN_WHITE = 2'd1,
    RUN_BLACK = 2'd2,
    TIMEOUT   = 2'd3
  } state_e;

  state_e          state_q, state_d;
  logic [7:0]      time_white_q, time_white_d;
  logic [7:0]      time_black_q, time_black_d;
  logic [PW-1:0]   prescaler_q, prescaler_d;
  logic            active_black_q, active_black_d;
  logic            running_q, running_d;
  logic            counting;
  logic            tick;
  logic [7:0]      active_time;

  // NOTE: reset is sampled on the clock edge, so it lives inside the clocked
  // block rather than in the sensitivity list.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= IDLE;
      time_white_q   <= START_TIME;
      time_black_q   <= START_TIME;
      prescaler_q    <= '0;
      active_black_q <= 1'b0;
      running_q      <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge values computed by the next-state logic.
      state_q        <= state_d;
      time_white_q   <= time_white_d;
      time_black_q   <= time_black_d;
      prescaler_q    <= prescaler_d;
      active_black_q <= active_black_d;
      running_q      <= running_d;
    end
  end

  // NOTE: every signal written here gets a default first, so no path
  // through the case statement can infer a latch.
  always_comb begin
    state_d        = state_q;
    time_white_d   = time_white_q;
    time_black_d   = time_black_q;
    prescaler_d    = prescaler_q;
    active_black_d = active_black_q;
    counting       = 1'b0;
    tick           = 1'b0;
    active_time    = active_black_q ? time_black_q : time_white_q;

    unique case (state_q)
      IDLE, TIMEOUT: begin
        if (start) begin
          state_d        = RUN_WHITE;
          time_white_d   = START_TIME;
          time_black_d   = START_TIME;
          prescaler_d    = '0;
          active_black_d = 1'b0;
        end
      end
      RUN_WHITE, RUN_BLACK: begin
        counting = !pause;
        tick     = counting && (prescaler_q == PRESC_MAX);
        if (counting) prescaler_d = tick ? '0 : prescaler_q + 1'b1;

        // The tick is charged to the outgoing player before any turn switch.
        if (tick && active_time != 8'd0) begin
          if (active_black_q) time_black_d = time_black_q - 8'd1;
          else                time_white_d = time_white_q - 8'd1;
        end

        if (tick && active_time == 8'd1) begin
          state_d = TIMEOUT;
        end else if (move_done) begin
          state_d        = active_black_q ? RUN_WHITE : RUN_BLACK;
          active_black_d = !active_black_q;
          prescaler_d    = '0;
        end
      end
      default: ;
    endcase

    running_d = ((state_d == RUN_WHITE) || (state_d == RUN_BLACK)) && !pause;
  end

  always_comb begin
    time_white    = time_white_q;
    time_black    = time_black_q;
    active_black  = active_black_q;
    running       = running_q;
    timeout       = (state_q == TIMEOUT);
    display_value = active_black_q ? time_black_q : time_white_q;
  end

endmodule

// File: doc/chess_clock_timer.md
Name: chess_clock_timer

Overview:
- Two-player chess clock: one countdown per player, in whole seconds, 8-bit range.
- Sits directly upstream of the binary-to-BCD seven-segment display stage. display_value drives that stage's 8-bit binary input, so the active player's remaining seconds (0..255) appear on HEX2..HEX0.
- Turn-switch and start/pause controls come from debounced, single-cycle-pulsed board keys and switches.

Parameters:
- CLK_HZ, 50000000, clock cycles per one-second tick; range 2..2^26.
- START_SECONDS, 180, per-player initial time loaded on reset/start; range 1..255.

Ports:
- clk  input  1  system clock; all logic rising-edge.
- reset  input  1  synchronous, active-high; dominates all other inputs.
- start  input  1  one-cycle pulse; (re)starts a game from IDLE or TIMEOUT.
- move_done  input  1  one-cycle pulse; active player ends turn.
- pause  input  1  level; while high in a RUN state, time does not elapse.
- time_white  output  8  white remaining seconds.
- time_black  output  8  black remaining seconds.
- display_value  output  8  remaining seconds of active player, to display stage.
- active_black  output  1  0 = white to move, 1 = black to move.
- running  output  1  high in RUN_WHITE/RUN_BLACK with pause low.
- timeout  output  1  high in TIMEOUT state.

Behaviour:
- Interface: one clock, clk. reset is synchronous and active-high.
- All outputs are registered, or decoded from registers only; no combinational input-to-output paths.
- Reset values:
  - state = IDLE
  - time_white = time_black = START_SECONDS
  - prescaler = 0, active_black = 0
  - running = 0, timeout = 0
  - display_value = START_SECONDS
- States: IDLE, RUN_WHITE, RUN_BLACK, TIMEOUT. active_black = 1 exactly in RUN_BLACK, and in TIMEOUT when black flagged.
- Transitions:
  - IDLE: start -> reload both times to START_SECONDS, prescaler = 0, go to RUN_WHITE. move_done and pause are ignored.
  - RUN_WHITE / RUN_BLACK, no tick: move_done -> other RUN state, prescaler cleared to 0; the unfinished fraction of a second is discarded. start is ignored.
  - RUN_WHITE / RUN_BLACK, tick: see the tick and simultaneous-event rules below.
  - TIMEOUT: holds all values. start -> reload both, go to RUN_WHITE, active_black = 0. move_done and pause are ignored.
- Prescaler: increments only in a RUN state with pause = 0.
  - Tick = prescaler == CLK_HZ-1 and counting; on tick, prescaler wraps to 0.
  - On tick, the active player's time decrements by 1.
  - Paused: prescaler and times hold their values, so the fraction of a second is kept.
- Zero / wrap rules:
  - A decrement from 1 to 0 enters TIMEOUT in the same edge; time stays 0.
  - Time never wraps below 0 and never decrements in IDLE or TIMEOUT.
- Simultaneous tick + move_done: the tick applies to the outgoing player first.
  - If that reaches 0, go to TIMEOUT (flagging the outgoing player); the switch is dropped.
  - Otherwise switch players, with prescaler = 0.
- move_done while paused: the switch is taken and prescaler is cleared; the state remains paused.
- display_value = time_black if active_black else time_white; updates in the same cycle as the selected register.
- reset asserted mid-game returns to the reset values on the next edge, regardless of start/move_done.
- Latency: the countdown registers change on the edge where tick is true. Outputs reflect the change the next cycle after that edge.
- Width: times are 8-bit unsigned. prescaler is ceil(log2(CLK_HZ)) bits.

Test Plan (CLK_HZ=4, START_SECONDS=3):
- Reset, then start pulse:
  - After 4 clocks: time_white=2, display_value=2.
  - After 12 clocks: time_white=0, timeout=1, active_black=0, time_black=3.
- start, 6 clocks, then move_done (prescaler at 2):
  - After the pulse: time_white=2, active_black=1, prescaler=0.
  - 4 more clocks: time_black=2, time_white still 2.
- start, 2 clocks, pause high 10 clocks, pause low:
  - Times unchanged while paused; running=0.
  - 2 clocks after release: time_white=2.
- move_done coincident with tick while time_white=1: time_white=0, timeout=1, active_black=0, no switch to black.
- In TIMEOUT, pulse start: time_white=time_black=3, RUN_WHITE, timeout=0. Also confirm start mid-game is ignored.
- reset asserted in RUN_BLACK with time_black=1 and start high in the same cycle: IDLE, both times 3, active_black=0, running=0.
